// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: pitch codes, tone half-period table,
// FSM state encoding and note field widths.
package melody_pkg;

    localparam int PITCH_W   = 4;
    localparam int HALF_W    = 18;
    localparam int NUM_TONES = 14;

    localparam logic [PITCH_W-1:0] PITCH_REST = 4'd0;
    localparam logic [PITCH_W-1:0] PITCH_END  = 4'd15;

    // Half-period in clock cycles for L_1..L_7, M_1..M_7 (pitch codes 1..14)
    localparam logic [HALF_W-1:0] HALF_TABLE [NUM_TONES] = '{
        18'd127552, 18'd113636, 18'd101236, 18'd95548, 18'd85136, 18'd75838, 18'd67567,
        18'd63776,  18'd56818,  18'd50607,  18'd47778, 18'd42553, 18'd37936, 18'd33783
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    function automatic logic [HALF_W-1:0] half_cycles(input logic [PITCH_W-1:0] pitch);
        logic [HALF_W-1:0] half;
        half = '0;
        if (pitch != PITCH_REST && pitch != PITCH_END)
            half = HALF_TABLE[pitch - 4'd1];
        return half;
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: toggles wave each time the counter reaches half-1.
// Counter and wave clear whenever en is low, so every tone starts at phase 0.
module tone_divider
    import melody_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [HALF_W-1:0] half,
    output logic              wave
);

    logic [HALF_W-1:0] r_cnt;
    logic              r_wave;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (!en) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (r_cnt == half - HALF_W'(1)) begin
            r_cnt  <= '0;
            r_wave <= ~r_wave;
        end else begin
            r_cnt <= r_cnt + HALF_W'(1);
        end
    end

    assign wave = r_wave;

endmodule

// File: rtl/melody_sequencer.sv
// Plays a song from a writable note RAM onto the buzzer: FETCH (1 cycle), PLAY (dur+1 beats),
// GAP (silent). start->busy in 1 cycle, tone from 2 cycles; stop aborts immediately.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 1000000,
    parameter int unsigned SONG_DEPTH  = 64,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DUR_W       = 3,
    parameter int unsigned PITCH_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [PITCH_W+DUR_W-1:0] wr_data,
    output logic                     beep,
    output logic                     sd,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        cur_addr
);

    localparam longint unsigned PLAY_MAX = (64'd1 << DUR_W) * 64'(BEAT_CYCLES);
    localparam longint unsigned CNT_MAX  = (PLAY_MAX > 64'(GAP_CYCLES)) ? PLAY_MAX : 64'(GAP_CYCLES);
    localparam int              CNT_W    = $clog2(CNT_MAX + 64'd1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_DEPTH - 1);

    logic [PITCH_W+DUR_W-1:0] r_mem [SONG_DEPTH];
    logic [PITCH_W+DUR_W-1:0] r_rd_data;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [CNT_W-1:0]    r_cnt;
    logic [PITCH_W-1:0]  r_pitch;
    logic [DUR_W-1:0]    r_dur;
    logic                r_done;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_done_nxt;
    logic                w_end;
    logic [PITCH_W-1:0]  w_rd_pitch;
    logic [DUR_W-1:0]    w_rd_dur;
    logic [CNT_W-1:0]    w_play_last;
    logic [HALF_W-1:0]   w_half;
    logic                w_tone_en;
    logic                w_wave;

    assign w_rd_pitch  = r_rd_data[PITCH_W+DUR_W-1 -: PITCH_W];
    assign w_rd_dur    = r_rd_data[DUR_W-1:0];
    assign w_play_last = CNT_W'((64'(r_dur) + 64'd1) * 64'(BEAT_CYCLES) - 64'd1);

    // The read address is the next cur_addr, so the word is ready during FETCH.
    always_ff @(posedge clk) begin
        if (wr_en && r_state == ST_IDLE)
            r_mem[wr_addr] <= wr_data;
        r_rd_data <= r_mem[w_addr_nxt];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cur_addr <= '0;
            r_cnt      <= '0;
            r_pitch    <= PITCH_REST;
            r_dur      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_addr <= w_addr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_done     <= w_done_nxt;
            if (r_state == ST_FETCH) begin
                r_pitch <= w_rd_pitch;
                r_dur   <= w_rd_dur;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_cur_addr;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_end       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_FETCH;
                    w_addr_nxt  = '0;
                end
            end
            ST_FETCH: begin
                w_cnt_nxt = '0;
                if (w_rd_pitch == PITCH_END)
                    w_end = 1'b1;
                else
                    w_state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (r_cnt == w_play_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_cur_addr == LAST_ADDR) begin
                        w_end = 1'b1;
                    end else begin
                        w_addr_nxt  = r_cur_addr + ADDR_W'(1);
                        w_state_nxt = ST_FETCH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // End of song: either an END marker or running past the last entry.
        if (w_end) begin
            if (loop_en) begin
                w_addr_nxt  = '0;
                w_state_nxt = ST_FETCH;
            end else begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end
        end

        if (stop) begin
            w_state_nxt = ST_IDLE;
            w_addr_nxt  = r_cur_addr;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b0;
        end
    end

    assign w_half    = half_cycles(r_pitch) >> PITCH_SHIFT;
    assign w_tone_en = (r_state == ST_PLAY) && (r_pitch != PITCH_REST);

    tone_divider u_tone (
        .clk  (clk),
        .rst  (rst),
        .en   (w_tone_en),
        .half (w_half),
        .wave (w_wave)
    );

    assign beep     = (r_state == ST_PLAY) && w_wave;
    assign busy     = (r_state != ST_IDLE);
    assign sd       = busy;
    assign done     = r_done;
    assign cur_addr = r_cur_addr;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: directed and random songs compared cycle by cycle
// against an expected output timeline built from the note list.
module tb_melody_sequencer;

    localparam int BEAT  = 200;
    localparam int GAP   = 20;
    localparam int SHIFT = 10;
    localparam int DEPTH = 64;
    localparam int BIG   = 1 << 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, loop_en, wr_en;
    logic [5:0] wr_addr;
    logic [6:0] wr_data;
    logic       beep, sd, busy, done;
    logic [5:0] cur_addr;

    int checks = 0;
    int errors = 0;
    int cyc_idx = 0;

    typedef struct packed {
        logic       beep;
        logic       busy;
        logic       done;
        logic [5:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   m_pitch [DEPTH];
    int   m_dur   [DEPTH];
    int   tb_half [14] = '{127552, 113636, 101236, 95548, 85136, 75838, 67567,
                           63776, 56818, 50607, 47778, 42553, 37936, 33783};

    always #5 clk = ~clk;

    melody_sequencer #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP),
        .SONG_DEPTH  (DEPTH),
        .ADDR_W      (6),
        .DUR_W       (3),
        .PITCH_SHIFT (SHIFT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .beep     (beep),
        .sd       (sd),
        .busy     (busy),
        .done     (done),
        .cur_addr (cur_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %0d expected %0d", tag, cyc_idx, obs, expv);
        end
    endtask

    function automatic void push(input int b, input int bz, input int d, input int a);
        exp_t e;
        e.beep = b[0];
        e.busy = bz[0];
        e.done = d[0];
        e.addr = a[5:0];
        exp_q.push_back(e);
    endfunction

    // Timeline of outputs starting with the cycle after start is sampled.
    function automatic void build_trace(input int passes);
        int addr;
        int half;
        bit fin;
        addr = 0;
        exp_q.delete();
        for (int p = 0; p < passes; p++) begin
            addr = 0;
            fin  = 0;
            while (!fin) begin
                push(0, 1, 0, addr);
                if (m_pitch[addr] == 15) begin
                    fin = 1;
                end else begin
                    half = (m_pitch[addr] == 0) ? 0 : (tb_half[m_pitch[addr] - 1] >> SHIFT);
                    for (int k = 0; k < (m_dur[addr] + 1) * BEAT; k++)
                        push((half == 0) ? 0 : ((k / half) % 2), 1, 0, addr);
                    for (int k = 0; k < GAP; k++)
                        push(0, 1, 0, addr);
                    if (addr == DEPTH - 1) fin = 1;
                    else addr++;
                end
            end
        end
        push(0, 0, 1, addr);
        push(0, 0, 0, addr);
    endfunction

    task automatic write_note(input int a, input int p, input int d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a[5:0];
        wr_data = {p[3:0], d[2:0]};
        m_pitch[a] = p;
        m_dur[a]   = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Entered at a negedge: pulses start, then checks up to limit cycles of the timeline.
    // wr_at = -2 issues a write to address 0 together with start.
    task automatic run_trace(input int limit, input int start_at, input int drop_at,
                             input int wr_at, input int waddr, input logic [6:0] wdat);
        int n;
        n = (limit < exp_q.size()) ? limit : exp_q.size();
        start = 1'b1;
        if (wr_at == -2) begin
            wr_en   = 1'b1;
            wr_addr = 6'd0;
            wr_data = wdat;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start   = 1'b0;
            wr_en   = 1'b0;
            cyc_idx = i;
            chk("beep",     beep,     exp_q[i].beep);
            chk("busy",     busy,     exp_q[i].busy);
            chk("sd",       sd,       exp_q[i].busy);
            chk("done",     done,     exp_q[i].done);
            chk("cur_addr", cur_addr, exp_q[i].addr);
            if (i == start_at) start = 1'b1;
            if (i == wr_at) begin
                wr_en   = 1'b1;
                wr_addr = waddr[5:0];
                wr_data = wdat;
            end
            if (i == drop_at) loop_en = 1'b0;
        end
    endtask

    initial begin
        int len;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #3;
        chk("rst_beep", beep, 0);
        chk("rst_sd",   sd,   0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", cur_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single M_1 note then END
        write_note(0, 8, 0);
        write_note(1, 15, 0);
        build_trace(1);
        run_trace(BIG, -1, -1, -1, 0, 7'd0);

        // Rest of 3 beats, then M_7 for 2 beats
        write_note(0, 0, 2);
        write_note(1, 14, 1);
        write_note(2, 15, 0);
        build_trace(1);
        run_trace(BIG, -1, -1, -1, 0, 7'd0);

        // Repeated note; a write to address 0 alongside start must not affect the first fetch
        write_note(0, 11, 0);
        write_note(1, 11, 0);
        write_note(2, 15, 0);
        build_trace(1);
        run_trace(BIG, -1, -1, -2, 0, {4'd3, 3'd1});
        m_pitch[0] = 3;
        m_dur[0]   = 1;
        build_trace(1);
        run_trace(BIG, -1, -1, -1, 0, 7'd0);

        // Random short songs; the first starts with a maximum-length note
        for (int r = 0; r < 3; r++) begin
            len = $urandom_range(1, 5);
            for (int j = 0; j < len; j++)
                write_note(j, $urandom_range(0, 14), (r == 0 && j == 0) ? 7 : $urandom_range(0, 3));
            write_note(len, 15, 0);
            build_trace(1);
            run_trace(BIG, -1, -1, -1, 0, 7'd0);
        end

        // Full RAM without END: wrap once in loop mode, then finish after the second pass
        for (int a = 0; a < DEPTH; a++)
            write_note(a, $urandom_range(0, 14), 0);
        loop_en = 1'b1;
        build_trace(2);
        run_trace(BIG, -1, DEPTH * (1 + BEAT + GAP) + 50, -1, 0, 7'd0);

        // Stop at PLAY cycle 100 of the second note; start and write while busy are ignored
        write_note(0, 9, 0);
        write_note(1, 5, 3);
        write_note(2, 15, 0);
        build_trace(1);
        run_trace(1 + BEAT + GAP + 1 + 101, 150, -1, 250, 2, {4'd1, 3'd0});
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_beep", beep, 0);
        chk("stop_busy", busy, 0);
        chk("stop_sd",   sd,   0);
        chk("stop_done", done, 0);
        chk("stop_addr", cur_addr, 1);
        repeat (5) begin
            @(negedge clk);
            chk("stop_idle_done", done, 0);
            chk("stop_idle_busy", busy, 0);
        end

        // Asynchronous reset in mid-note, then replay from intact RAM
        build_trace(1);
        run_trace(300, -1, -1, -1, 0, 7'd0);
        #1 rst = 1'b1;
        #1;
        chk("arst_beep", beep, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sd",   sd,   0);
        chk("arst_done", done, 0);
        chk("arst_addr", cur_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        run_trace(BIG, -1, -1, -1, 0, 7'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Parametrised successor to the fixed-tune buzzer player. It plays a song held in an internal writable note RAM of SONG_DEPTH entries, where each entry holds a pitch index and a duration. It adds start/stop control, loop mode, rests, an end-of-song marker, and a silent articulation gap so that repeated notes stay distinct. It drives the board buzzer (beep) and the amplifier shutdown pin (sd), under control of the clock top level.

Parameters:
BEAT_CYCLES, 25000000, clk cycles per duration unit (500 ms at 50 MHz)
GAP_CYCLES, 1000000, silent cycles after every note or rest
SONG_DEPTH, 64, note RAM entries
ADDR_W, 6, note RAM address width, at least clog2(SONG_DEPTH)
DUR_W, 3, duration field width; a note lasts (dur+1) beats
PITCH_SHIFT, 0, right shift applied to every half-period table value (simulation speed-up)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  pulse; begins playback at address 0 when idle
stop  in  1  pulse; aborts playback
loop_en  in  1  sampled at end of song; 1 = restart at address 0
wr_en  in  1  note RAM write strobe
wr_addr  in  ADDR_W  note RAM write address
wr_data  in  4+DUR_W  {pitch[3:0], dur[DUR_W-1:0]}
beep  out  1  square-wave buzzer drive
sd  out  1  amplifier enable; 1 while busy
busy  out  1  1 in any state other than IDLE
done  out  1  one-cycle pulse at natural (non-loop) end of song
cur_addr  out  ADDR_W  address of the note currently sounding

Behaviour:
- Reset (async): state=IDLE, beep=0, sd=0, busy=0, done=0, cur_addr=0, all counters 0. Note RAM contents are not reset.
- Pitch encoding: 0 = rest, 1..7 = L_1..L_7, 8..14 = M_1..M_7, 15 = END marker.
- Half-period table, in clk cycles, toggle count: 127552, 113636, 101236, 95548, 85136, 75838, 67567, 63776, 56818, 50607, 47778, 42553, 37936, 33783. The table is right-shifted by PITCH_SHIFT.
- FSM states: IDLE, FETCH, PLAY, GAP.
  - IDLE: start=1 -> FETCH with cur_addr=0.
  - FETCH: lasts 1 cycle (synchronous RAM read); latch pitch and dur. If pitch=15, go to end handling. Otherwise go to PLAY and clear the beat and tone counters.
  - PLAY: lasts exactly (dur+1)*BEAT_CYCLES cycles, then -> GAP.
  - GAP: lasts exactly GAP_CYCLES cycles with beep=0. Then, if cur_addr=SONG_DEPTH-1, go to end handling; otherwise increment cur_addr and go to FETCH.
  - End handling: if loop_en=1, set cur_addr=0 and go to FETCH. Otherwise pulse done for 1 cycle and go to IDLE.
- Tone generation in PLAY:
  - For pitch 1..14, the tone counter starts at 0 on PLAY entry and beep starts at 0.
  - beep toggles when the counter equals half-1; the counter then returns to 0. This gives first toggle after `half` cycles and period 2*half.
  - For a rest, beep is held at 0.
- beep=0 in IDLE, FETCH and GAP. Every note therefore starts from a known phase.
- Latency: start at cycle t -> busy=sd=1 at t+1 (FETCH) -> PLAY at t+2.
- stop=1 in any state: next cycle IDLE with beep=0, busy=0, cur_addr held, and no done pulse. stop and start in the same cycle: stop wins.
- start while busy is ignored (no restart).
- RAM writes:
  - accepted only when busy=0; ignored while busy.
  - a write in the same cycle as an accepted start is performed, but the first FETCH reads the pre-write contents only if wr_addr=0.
- A dur field of all ones gives 2^DUR_W beats. Beat counter width must hold 2^DUR_W*BEAT_CYCLES without overflow.
- done is registered and is never asserted while busy is asserted on the same cycle after the IDLE transition.

Decomposition:
- Package melody_pkg holds:
  - the pitch index constants (REST=0, END=15);
  - the 14-entry half-period table;
  - the state encoding constants for IDLE/FETCH/PLAY/GAP;
  - the note field widths.
- One sub-module, tone_divider: inputs clk, rst, en, half[17:0]; output wave. It clears on en falling and implements the toggle-at-half-1 rule.
- The note RAM is inferred inside melody_sequencer.

Test Plan:
Bench parameters for all cases: PITCH_SHIFT=10, BEAT_CYCLES=200, GAP_CYCLES=20.
- Basic note: write addr0={8,0} (M_1), addr1={15,0}; pulse start. Require:
  - PLAY from t+2 for 200 cycles;
  - beep period 2*62=124 cycles (63776>>10=62), first toggle 62 cycles after PLAY entry;
  - done pulse 1 cycle after GAP ends;
  - busy=0 afterwards.
- Rest and duration: addr0={0,2}, addr1={14,1}, addr2={15,0}. Require beep=0 for 600+20 cycles, then half-period 32 (33783>>10) for 400 cycles.
- Repeated note gap: two consecutive {11,0} entries. Require beep=0 for exactly 20 cycles between them and the second note restarting from phase 0.
- Loop and wrap: loop_en=1, song with no END marker filling all 64 entries. Require cur_addr to go 63 -> 0 with no done; then deassert loop_en and require done after the next pass through entry 63.
- Stop mid-note: stop in cycle 100 of PLAY. Require IDLE next cycle with beep=sd=busy=0 and no done. A start issued while busy is ignored, with no change to cur_addr.
- Reset mid-operation: assert rst asynchronously during PLAY. Require outputs cleared within the same cycle (before the next clk edge) and RAM contents intact on replay.
